banked_rf_param: RTL

//  Parametrised banked register file with one dual-push / single-pop request FIFO per bank.

---
 rtl/banked_rf_pkg.sv | 27 ++
 rtl/Single_Port_BRAM.sv | 22 ++
 rtl/rf_req_fifo.sv | 59 +++++
 rtl/banked_rf_param.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/banked_rf_pkg.sv
// rtl/banked_rf_pkg.sv - shared defaults, width helpers and enums for the banked register file
package banked_rf_pkg;

  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_LANES      = 8;
  localparam int DEF_LANE_W     = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_OC_ENTRIES = 4;

  // Which source operand of the instruction a read request serves
  typedef enum logic {
    SRC1 = 1'b0,
    SRC2 = 1'b1
  } src_id_e;

  // Index width that never collapses to zero bits
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy counter width: must be able to represent a completely full FIFO
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/Single_Port_BRAM.sv
// rtl/Single_Port_BRAM.sv - single-port block RAM with registered read data
module Single_Port_BRAM #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-first synchronous RAM
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/rf_req_fifo.sv
// rtl/rf_req_fifo.sv - per-bank read-request FIFO with two ordered push ports and one pop port
module rf_req_fifo #(
  parameter  int DEPTH = 8,
  parameter  int DW    = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en0,
  input  logic [DW-1:0] wr_data0,
  input  logic          wr_en1,
  input  logic [DW-1:0] wr_data1,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic [CW-1:0] free,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr1;

  // Port 1 lands behind port 0 when both push in the same cycle
  assign wptr1   = wptr + PW'(wr_en0);
  assign rd_data = mem[rptr];
  assign empty   = (count == '0);
  assign free    = CW'(DEPTH) - count;

  // Entry storage; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wptr]  <= wr_data0;
    if (wr_en1) mem[wptr1] <= wr_data1;
  end

  // Pointer and occupancy tracking; flush discards everything queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(wr_en0) + PW'(wr_en1);
      rptr  <= rptr + PW'(rd_en);
      count <= count + CW'(wr_en0) + CW'(wr_en1) - CW'(rd_en);
    end
  end

  // Upstream only pushes when enough room was reported
  assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));

endmodule

// File: rtl/banked_rf_param.sv
// rtl/banked_rf_param.sv - parametrised banked register file with per-bank read-request FIFOs
module banked_rf_param
  import banked_rf_pkg::*;
#(
  parameter  int NUM_BANKS  = DEF_NUM_BANKS,
  parameter  int NUM_REGS   = DEF_NUM_REGS,
  parameter  int LANES      = DEF_LANES,
  parameter  int LANE_W     = DEF_LANE_W,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter  int OC_ENTRIES = DEF_OC_ENTRIES,
  localparam int AW         = $clog2(NUM_REGS),
  localparam int BW         = $clog2(NUM_BANKS),
  localparam int RW         = AW - BW,
  localparam int ENT_W      = idx_w(OC_ENTRIES),
  localparam int CW         = cnt_w(FIFO_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ENT_W-1:0]                req_entry,
  input  logic                            src1_vld,
  input  logic [AW-1:0]                   src1_addr,
  input  logic                            src2_vld,
  input  logic [AW-1:0]                   src2_addr,
  input  logic                            flush,
  input  logic                            wb_valid,
  input  logic [LANES-1:0]                wb_mask,
  input  logic [AW-1:0]                   wb_addr,
  input  logic [LANES*LANE_W-1:0]         wb_data,
  output logic [NUM_BANKS-1:0]            rd_valid,
  output logic [NUM_BANKS*LANES*LANE_W-1:0] rd_data,
  output logic [NUM_BANKS*ENT_W-1:0]      rd_entry,
  output logic [NUM_BANKS-1:0]            rd_src,
  output logic [NUM_BANKS*CW-1:0]         fifo_count
);

  localparam int ROWS = NUM_REGS / NUM_BANKS;

  typedef struct packed {
    src_id_e          src_id;
    logic [ENT_W-1:0] entry;
    logic [RW-1:0]    row;
  } req_t;

  localparam int DW = $bits(req_t);

  req_t                 ent1;
  req_t                 ent2;
  logic [RW-1:0]        wb_row;
  logic [NUM_BANKS-1:0] s1_hit;
  logic [NUM_BANKS-1:0] s2_hit;
  logic [NUM_BANKS-1:0] wb_hit;
  logic [NUM_BANKS-1:0] bank_ok;
  logic [CW-1:0]        free_cnt [NUM_BANKS];
  logic                 fire;

  assign ent1   = '{src_id: SRC1, entry: req_entry, row: src1_addr[AW-1:BW]};
  assign ent2   = '{src_id: SRC2, entry: req_entry, row: src2_addr[AW-1:BW]};
  assign wb_row = wb_addr[AW-1:BW];

  // Bank decode of both sources and the writeback, plus per-bank room check
  always_comb begin
    s1_hit  = '0;
    s2_hit  = '0;
    wb_hit  = '0;
    bank_ok = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      s1_hit[b]  = src1_vld && (src1_addr[BW-1:0] == BW'(b));
      s2_hit[b]  = src2_vld && (src2_addr[BW-1:0] == BW'(b));
      wb_hit[b]  = wb_valid && (wb_addr[BW-1:0] == BW'(b));
      bank_ok[b] = free_cnt[b] >= (CW'(s1_hit[b]) + CW'(s2_hit[b]));
    end
  end

  // Whole request is accepted only if every bank it touches can take its share
  assign req_ready = !flush && (&bank_ok);
  assign fire      = req_valid && req_ready;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    req_t             wdata0;
    req_t             head;
    logic             push0;
    logic             push1;
    logic             pop;
    logic             empty;
    logic [CW-1:0]    count;
    logic [RW-1:0]    ram_row;
    logic             v_q;
    logic [ENT_W-1:0] ent_q;
    logic             src_q;

    // src1 always occupies the first slot when both sources hit this bank
    assign push0   = fire && (s1_hit[b] || s2_hit[b]);
    assign push1   = fire && s1_hit[b] && s2_hit[b];
    assign wdata0  = s1_hit[b] ? ent1 : ent2;
    // Writeback owns the RAM port; the queued read simply waits
    assign pop     = !empty && !wb_hit[b] && !flush;
    assign ram_row = wb_hit[b] ? wb_row : head.row;

    rf_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (DW)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .wr_en0   (push0),
      .wr_data0 (wdata0),
      .wr_en1   (push1),
      .wr_data1 (ent2),
      .rd_en    (pop),
      .rd_data  (head),
      .count    (count),
      .free     (free_cnt[b]),
      .empty    (empty)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
      Single_Port_BRAM #(
        .DATA_W (LANE_W),
        .DEPTH  (ROWS)
      ) u_ram (
        .clk  (clk),
        .we   (wb_hit[b] && wb_mask[k]),
        .addr (ram_row),
        .din  (wb_data[k*LANE_W +: LANE_W]),
        .dout (rd_data[(b*LANES+k)*LANE_W +: LANE_W])
      );
    end

    // Read metadata travels alongside the one-cycle RAM latency
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        ent_q <= '0;
        src_q <= 1'b0;
      end else begin
        v_q <= pop;
        if (pop) begin
          ent_q <= head.entry;
          src_q <= head.src_id;
        end
      end
    end

    assign rd_valid[b]                = v_q;
    assign rd_entry[b*ENT_W +: ENT_W] = ent_q;
    assign rd_src[b]                  = src_q;
    assign fifo_count[b*CW +: CW]     = count;
  end

endmodule
